// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Glyph patterns are active-high with bit 0 = segment a, bit 6 = segment g.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    localparam seg_t GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-high seven-segment pattern lookup.
module hex_to_seg
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    assign seg_o = GLYPHS[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with a load-strobed shadow register.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 excepted).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV   = 100_000
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [4*NUM_DIGITS-1:0] val_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load_in,
    input  logic                    en_in,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [6:0]              cat_out,
    output logic                    dp_out
);

    localparam int unsigned DivW = $clog2(SCAN_DIV);
    localparam int unsigned IdxW = $clog2(NUM_DIGITS);
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] val_q, val_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [DivW-1:0]         div_cnt_q, div_cnt_d;
    logic [IdxW-1:0]         digit_idx_q, digit_idx_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    seg_t                    cat_q, cat_d;
    logic                    dp_out_q, dp_out_d;

    logic [3:0] nibble;
    seg_t       seg;
    logic       lz_blank;

    assign nibble = val_q[{digit_idx_q, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble_i (nibble),
        .seg_o    (seg)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Selected nibble and everything above it zero means a leading zero.
    assign lz_blank = (digit_idx_q != '0) && ((val_q >> {digit_idx_q, 2'b00}) == '0);
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        val_d       = val_q;
        dp_d        = dp_q;
        div_cnt_d   = div_cnt_q;
        digit_idx_d = digit_idx_q;

        if (load_in) begin
            val_d = val_in;
            dp_d  = dp_in;
        end

        if (en_in) begin
            if (div_cnt_q == DivLast) begin
                div_cnt_d   = '0;
                digit_idx_d = (digit_idx_q == IdxLast) ? '0 : digit_idx_q + 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        an_d     = '1;
        cat_d    = SEG_OFF;
        dp_out_d = 1'b1;
        if (en_in) begin
            an_d     = ~(NUM_DIGITS'(1) << digit_idx_q);
            cat_d    = lz_blank ? SEG_OFF : ~seg;
            dp_out_d = ~dp_q[digit_idx_q];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            val_q       <= '0;
            dp_q        <= '0;
            div_cnt_q   <= '0;
            digit_idx_q <= '0;
            an_q        <= '1;
            cat_q       <= SEG_OFF;
            dp_out_q    <= 1'b1;
        end else begin
            val_q       <= val_d;
            dp_q        <= dp_d;
            div_cnt_q   <= div_cnt_d;
            digit_idx_q <= digit_idx_d;
            an_q        <= an_d;
            cat_q       <= cat_d;
            dp_out_q    <= dp_out_d;
        end
    end

    assign an_out  = an_q;
    assign cat_out = cat_q;
    assign dp_out  = dp_out_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a 4-digit and a 3-digit instance checked against a frame-level model.
module tb_seg7_scan_driver;

    localparam int SCAN = 4;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] MIDLOAD_CAT = 7'h7F;
`else
    localparam logic [6:0] MIDLOAD_CAT = 7'h40;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] val;
    logic [3:0]  dp;
    logic        load;
    logic        en;

    logic [3:0]  an4;
    logic [6:0]  cat4;
    logic        dpo4;
    logic [2:0]  an3;
    logic [6:0]  cat3;
    logic        dpo3;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (SCAN)
    ) dut4 (
        .clk_in  (clk),
        .rst_in  (rst),
        .val_in  (val),
        .dp_in   (dp),
        .load_in (load),
        .en_in   (en),
        .an_out  (an4),
        .cat_out (cat4),
        .dp_out  (dpo4)
    );

    seg7_scan_driver #(
        .NUM_DIGITS (3),
        .SCAN_DIV   (SCAN)
    ) dut3 (
        .clk_in  (clk),
        .rst_in  (rst),
        .val_in  (val[11:0]),
        .dp_in   (dp[2:0]),
        .load_in (load),
        .en_in   (en),
        .an_out  (an3),
        .cat_out (cat3),
        .dp_out  (dpo3)
    );

    int checks = 0;
    int errors = 0;

    // Model: number of enabled cycles since reset plus the captured value.
    int unsigned pos;
    logic [15:0] sh_val;
    logic [3:0]  sh_dp;
    logic [6:0]  glyph [16];

    typedef struct {
        logic        load;
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  an;
        logic [6:0]  cat;
        logic        dpo;
    } vec_t;

    vec_t tbl [17];

    task automatic cmp(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic void expect_out(input int n, input logic en_s, output logic [3:0] e_an,
                                       output logic [6:0] e_cat, output logic e_dp);
        int          d;
        logic [15:0] v;
        logic [3:0]  nib;
        v     = (n == 4) ? sh_val : (sh_val & 16'h0FFF);
        e_an  = 4'hF;
        e_cat = 7'h7F;
        e_dp  = 1'b1;
        if (en_s) begin
            d        = int'((pos / SCAN) % n);
            nib      = 4'((v >> (4 * d)) & 16'hF);
            e_an[d]  = 1'b0;
            e_cat    = ~glyph[nib];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (d > 0 && (v >> (4 * d)) == 16'h0) e_cat = 7'h7F;
`endif
            e_dp = ~sh_dp[d];
        end
    endfunction

    task automatic step(input logic l, input logic [15:0] v, input logic [3:0] d, input logic e);
        logic [3:0] ea4, ea3;
        logic [6:0] ec4, ec3;
        logic       ed4, ed3;
        load = l;
        val  = v;
        dp   = d;
        en   = e;
        expect_out(4, e, ea4, ec4, ed4);
        expect_out(3, e, ea3, ec3, ed3);
        @(posedge clk);
        #1;
        if (e) pos++;
        if (l) begin
            sh_val = v;
            sh_dp  = d;
        end
        cmp("model4", {an4, cat4, dpo4}, {ea4, ec4, ed4});
        cmp("model3", {1'b0, an3, cat3, dpo3}, {1'b0, ea3[2:0], ec3, ed3});
    endtask

    initial begin
        bit found;

        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

        // Load 1A2F on the first edge, then one full frame plus one cycle.
        tbl[0] = '{1'b1, 16'h1A2F, 4'b0100, 4'hE, 7'h40, 1'b1};
        for (int i = 1; i < 4; i++)  tbl[i] = '{1'b0, 16'h1A2F, 4'b0100, 4'hE, 7'h0E, 1'b1};
        for (int i = 4; i < 8; i++)  tbl[i] = '{1'b0, 16'h1A2F, 4'b0100, 4'hD, 7'h24, 1'b1};
        for (int i = 8; i < 12; i++) tbl[i] = '{1'b0, 16'h1A2F, 4'b0100, 4'hB, 7'h08, 1'b0};
        for (int i = 12; i < 16; i++) tbl[i] = '{1'b0, 16'h1A2F, 4'b0100, 4'h7, 7'h79, 1'b1};
        tbl[16] = '{1'b0, 16'h1A2F, 4'b0100, 4'hE, 7'h0E, 1'b1};

        rst    = 1'b1;
        en     = 1'b1;
        load   = 1'b0;
        val    = '0;
        dp     = '0;
        pos    = 0;
        sh_val = '0;
        sh_dp  = '0;

        #12;
        cmp("reset4", {an4, cat4, dpo4}, 12'hFFF);
        cmp("reset3", {1'b0, an3, cat3, dpo3}, 12'h7FF);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].load, tbl[i].val, tbl[i].dp, 1'b1);
            cmp("scan_tbl", {an4, cat4, dpo4}, {tbl[i].an, tbl[i].cat, tbl[i].dpo});
        end

        // Reach the start of digit 1's dwell, then reload mid-dwell.
        found = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if ((pos / SCAN) % 4 == 1 && pos % SCAN == 0) begin
                found = 1'b1;
                break;
            end
            step(1'b0, 16'h1A2F, 4'b0100, 1'b1);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL align_digit1: got no alignment expected digit 1 start");
        end
        step(1'b1, 16'h0007, 4'b0000, 1'b1);
        step(1'b0, 16'h0007, 4'b0000, 1'b1);
        cmp("midload", {1'b0, an4, cat4}, {1'b0, 4'hD, MIDLOAD_CAT});

        for (int i = 0; i < 10; i++) begin
            step(1'b0, 16'h0007, 4'b0000, 1'b0);
            cmp("en_off", {8'h0, an4}, {8'h0, 4'hF});
        end
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0007, 4'b0000, 1'b1);

        step(1'b1, 16'h0050, 4'b0000, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 16'h0050, 4'b0000, 1'b1);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 5) == 0), 16'($urandom), 4'($urandom),
                 1'($urandom_range(0, 7) != 0));
        end

        #2;
        rst = 1'b1;
        #1;
        cmp("rst_mid4", {an4, cat4, dpo4}, 12'hFFF);
        cmp("rst_mid3", {1'b0, an3, cat3, dpo3}, 12'h7FF);
        pos    = 0;
        sh_val = '0;
        sh_dp  = '0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 16'h0000, 4'b0000, 1'b1);
        cmp("rst_first", {8'h0, an4}, {8'h0, 4'hE});

        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(0, 5) == 0), 16'($urandom), 4'($urandom),
                 1'($urandom_range(0, 7) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a bank of common-anode seven-segment digits. It captures a packed hex word plus per-digit decimal points on a load strobe into a shadow register. It scans one digit at a time at a programmable rate and drives active-low anode and cathode lines straight to board pins. It is the parametrised successor of the single-digit hex decoder and sits between any value producer (UART receiver, counters, debug taps) and the display.

## Interface
- NUM_DIGITS, 8, number of digits scanned; legal range 2..16.
- SCAN_DIV, 100_000, clock cycles each digit stays lit; legal value ≥ 2.
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- val_in  input  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) is digit i, and digit 0 is the rightmost
- dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit
- load_in  input  1  single-cycle strobe that captures val_in and dp_in into the shadow register
- en_in  input  1  1 = display on; 0 = all anodes off
- an_out  output  NUM_DIGITS  anode selects, active-low, one-hot-low while scanning
- cat_out  output  7  segments a..g in bits 0..6, active-low
- dp_out  output  1  decimal point, active-low

## Operation
- Shadow register: `load_in`=1 at a rising edge captures `val_in` and `dp_in`. It holds otherwise. A new load overwrites mid-scan without restarting the scan.
- Scan counter:
  - `div_cnt` is $clog2(SCAN_DIV) bits and counts 0..SCAN_DIV-1.
  - When it wraps, `digit_idx` increments.
  - `digit_idx` is $clog2(NUM_DIGITS) bits. It wraps from NUM_DIGITS-1 to 0, and does so for non-power-of-two NUM_DIGITS too.
- Both counters run only while `en_in`=1. While `en_in`=0 they hold their values and the outputs are blanked.
- Decode: the shadow nibble at `digit_idx` goes through the hex-to-segment decoder.
  - Internal pattern is active-high, bit 0 = a.
  - 0→7E? No: use the standard hex glyphs. 0=a,b,c,d,e,f; 1=b,c; 2=a,b,d,e,g; 3=a,b,c,d,g; 4=b,c,f,g; 5=a,c,d,f,g; 6=a,c,d,e,f,g; 7=a,b,c; 8=all; 9=a,b,c,d,f,g; A=a,b,c,e,f,g; b=c,d,e,f,g; C=a,d,e,f; d=b,c,d,e,g; E=a,d,e,f,g; F=a,e,f,g.
- Output register:
  - `an_out` = ~(1 << digit_idx).
  - `cat_out` = ~pattern.
  - `dp_out` = ~dp[digit_idx].
  - All three are registered together so they switch in the same cycle.
- Blanked state: `an_out`, `cat_out` and `dp_out` all ones.

## Timing
- Reset values (asynchronous, while `rst_in`=1):
  - `an_out`, `cat_out` and `dp_out` are all ones.
  - `div_cnt` = 0 and `digit_idx` = 0.
  - The shadow register is all zero.
- First lit digit: digit 0 is driven on the first rising edge after `rst_in` falls with `en_in`=1.
- Output latency is one cycle from any change in `digit_idx`, shadow contents or `en_in`.
- Load latency: `load_in` sampled at edge k means the new data is visible on the outputs at edge k+1, if that digit is selected.
- Dwell time: each digit is lit for exactly SCAN_DIV cycles. A full frame is NUM_DIGITS*SCAN_DIV cycles.
- Reset asserted mid-scan blanks the outputs immediately (no clock required). The scan restarts at digit 0.
- `load_in` together with `en_in`=0: the capture still happens.

## Configuration
- SEG7_LEADING_ZERO_BLANK_EN defined:
  - Digit i>0 is blanked if its nibble and every higher nibble are zero. Blanking forces `cat_out`=7'h7F.
  - The anode is still asserted and `dp_out` still follows `dp_in`.
  - Digit 0 is never blanked.
- SEG7_LEADING_ZERO_BLANK_EN not defined: every digit shows its glyph, zeros included.

## Structure
- Package `seg7_pkg` holds:
  - the 16-entry glyph constant array (active-high, bit 0 = a);
  - the SEG_OFF constant (7'h7F);
  - the typedef `seg_t` (logic [6:0]).
- Sub-module `hex_to_seg` is purely combinational: 4-bit nibble in, `seg_t` out, reading from the package array. The top level instantiates one copy, on the selected nibble.

## Test plan
Bench settings: NUM_DIGITS=4, SCAN_DIV=4.
- Reset check: assert `rst_in` mid-scan → all outputs 1 in the same cycle. After release with `en_in`=1, `an_out`=4'b1110 after one edge.
- Load and scan: load `val_in`=16'h1A2F, `dp_in`=4'b0100 → over 16 cycles the outputs step through:
  - 1110/F(a,e,f,g);
  - 1101/2;
  - 1011/A with `dp_out`=0;
  - 0111/1.
  - Each step lasts 4 cycles.
- Mid-scan load: while digit 1 is lit, load 16'h0007 → from the next edge digit 1 shows 0 (or blank under the macro). The scan position is unchanged.
- Enable gating: drop `en_in` for 10 cycles → `an_out`=4'hF throughout. The scan resumes at the same `digit_idx`/`div_cnt`.
- Leading zeros, `val_in`=16'h0050:
  - Macro defined: digits 3 and 2 give `cat_out`=7'h7F, digit 1 shows 5, digit 0 shows 0.
  - Macro not defined: all four glyphs are shown.
- Non-power-of-two scan: NUM_DIGITS=3 → the anode sequence 110, 101, 011 repeats with no dark slot.
